// File: rtl/capture_uart_pkg.sv
// Shared types and sizing helpers for the capture-to-UART streamer.
// Holds the controller state encoding and the byte/count width calculations.
package capture_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FETCH,
        SEND,
        DONE
    } state_t;

    function automatic int nbytes_of(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Single-port capture buffer with a registered read, shaped for block RAM inference.
// The read returns the old contents when the same address is written in the same cycle.
module capture_ram #(
    parameter int  DATA_W = 40,
    parameter int  DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/capture_uart_streamer.sv
// Captures a contiguous burst of words into a buffer, then streams each word out
// as bytes over a valid/ready UART interface, optionally re-arming after each readout.
module capture_uart_streamer
    import capture_uart_pkg::*;
#(
    parameter int  DATA_W     = 40,
    parameter int  DEPTH      = 1024,
    parameter int  MSB_FIRST  = 0,
    parameter int  CONTINUOUS = 0,
    localparam int NBYTES     = nbytes_of(DATA_W),
    localparam int CW         = cw_of(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CW-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = NBYTES * 8;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state, state_next;
    logic [CW-1:0]     count_next;
    logic              overflow_next;
    logic [AW-1:0]     rd_ptr, rd_ptr_next;
    logic [BW-1:0]     byte_idx, byte_idx_next;
    logic              fetch_ready, fetch_ready_next;
    logic [SW-1:0]     shifter, shifter_next;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              buffer_full;
    logic              last_word;
    logic              last_byte;

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (in_data),
        .rdata (ram_rdata)
    );

    assign buffer_full = (count == CW'(DEPTH));
    assign last_word   = ((CW'(rd_ptr) + CW'(1)) == count);
    assign last_byte   = (byte_idx == BW'(NBYTES - 1));
    // The shifter is zero-extended on load, so the padded top byte goes out as 0x00.
    assign tx_byte     = (MSB_FIRST != 0) ? shifter[SW-1 -: 8] : shifter[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            overflow    <= 1'b0;
            rd_ptr      <= '0;
            byte_idx    <= '0;
            fetch_ready <= 1'b0;
            shifter     <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            overflow    <= overflow_next;
            rd_ptr      <= rd_ptr_next;
            byte_idx    <= byte_idx_next;
            fetch_ready <= fetch_ready_next;
            shifter     <= shifter_next;
        end
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        overflow_next    = overflow;
        rd_ptr_next      = rd_ptr;
        byte_idx_next    = byte_idx;
        fetch_ready_next = fetch_ready;
        shifter_next     = shifter;
        ram_we           = 1'b0;
        ram_addr         = rd_ptr;
        tx_valid         = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;

        unique case (state)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                end
            end

            ARMED: begin
                busy     = 1'b1;
                ram_addr = '0;
                if (in_valid) begin
                    ram_we        = 1'b1;
                    count_next    = CW'(1);
                    overflow_next = 1'b0;
                    state_next    = CAPTURE;
                end
            end

            // The write pointer is the word count itself; a full buffer drops words without wrapping.
            CAPTURE: begin
                busy     = 1'b1;
                ram_addr = count[AW-1:0];
                if (!in_valid) begin
                    rd_ptr_next      = '0;
                    fetch_ready_next = 1'b0;
                    state_next       = FETCH;
                end else if (buffer_full) begin
                    overflow_next = 1'b1;
                end else begin
                    ram_we     = 1'b1;
                    count_next = count + CW'(1);
                end
            end

            // First cycle presents the address, second cycle catches the registered read data.
            FETCH: begin
                busy = 1'b1;
                if (!fetch_ready) begin
                    fetch_ready_next = 1'b1;
                end else begin
                    fetch_ready_next = 1'b0;
                    shifter_next     = SW'(ram_rdata);
                    byte_idx_next    = '0;
                    state_next       = SEND;
                end
            end

            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    shifter_next = (MSB_FIRST != 0) ? (shifter << 8) : (shifter >> 8);
                    if (!last_byte) begin
                        byte_idx_next = byte_idx + BW'(1);
                    end else if (last_word) begin
                        state_next = DONE;
                    end else begin
                        rd_ptr_next = rd_ptr + AW'(1);
                        state_next  = FETCH;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = (CONTINUOUS != 0) ? ARMED : IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_capture_uart_streamer.sv
// Directed bench for capture_uart_streamer: three configurations share stimulus,
// a vector table covers the main readouts, and hand sequences cover reset and re-arm.
module tb_capture_uart_streamer;

    typedef struct packed {
        int               dut;
        int               nwords;
        int               stall;
        int               nbytes;
        int               exp_count;
        logic             exp_ovf;
        logic             exp_busy;
        logic [0:5][63:0] words;
        logic [0:23][7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  arm_v = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        tx_ready = 1'b1;

    logic        tx_valid0, tx_valid1, tx_valid2;
    logic [7:0]  tx_byte0, tx_byte1, tx_byte2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        ovf0, ovf1, ovf2;
    logic [10:0] count0;
    logic [2:0]  count1;
    logic [3:0]  count2;

    int          sel = 0;
    logic        m_valid, m_busy, m_done, m_ovf;
    logic [7:0]  m_byte;
    logic [15:0] m_count;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  byte_q[$];
    int          done_cnt;
    vec_t        vecs[5];

    always #5 clk = ~clk;

    // Default sizing, LSB first, one-shot.
    capture_uart_streamer #(.DATA_W(40), .DEPTH(1024), .MSB_FIRST(0), .CONTINUOUS(0)) dut0 (
        .clk(clk), .rst(rst), .arm(arm_v[0]), .in_valid(in_valid), .in_data(in_data[39:0]),
        .tx_ready(tx_ready), .tx_valid(tx_valid0), .tx_byte(tx_byte0), .busy(busy0),
        .done(done0), .overflow(ovf0), .count(count0)
    );

    // Tiny buffer, MSB first.
    capture_uart_streamer #(.DATA_W(40), .DEPTH(4), .MSB_FIRST(1), .CONTINUOUS(0)) dut1 (
        .clk(clk), .rst(rst), .arm(arm_v[1]), .in_valid(in_valid), .in_data(in_data[39:0]),
        .tx_ready(tx_ready), .tx_valid(tx_valid1), .tx_byte(tx_byte1), .busy(busy1),
        .done(done1), .overflow(ovf1), .count(count1)
    );

    // Non-byte-multiple width, re-arming after each readout.
    capture_uart_streamer #(.DATA_W(12), .DEPTH(8), .MSB_FIRST(0), .CONTINUOUS(1)) dut2 (
        .clk(clk), .rst(rst), .arm(arm_v[2]), .in_valid(in_valid), .in_data(in_data[11:0]),
        .tx_ready(tx_ready), .tx_valid(tx_valid2), .tx_byte(tx_byte2), .busy(busy2),
        .done(done2), .overflow(ovf2), .count(count2)
    );

    assign m_valid = (sel == 0) ? tx_valid0 : (sel == 1) ? tx_valid1 : tx_valid2;
    assign m_byte  = (sel == 0) ? tx_byte0  : (sel == 1) ? tx_byte1  : tx_byte2;
    assign m_busy  = (sel == 0) ? busy0     : (sel == 1) ? busy1     : busy2;
    assign m_done  = (sel == 0) ? done0     : (sel == 1) ? done1     : done2;
    assign m_ovf   = (sel == 0) ? ovf0      : (sel == 1) ? ovf1      : ovf2;
    assign m_count = (sel == 0) ? 16'(count0) : (sel == 1) ? 16'(count1) : 16'(count2);

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int dut, input int nwords, input logic [0:5][63:0] words, input bit do_arm);
        tx_ready = 1'b1;
        if (do_arm) begin
            arm_v[dut] = 1'b1;
            step();
            arm_v = '0;
        end
        for (int i = 0; i < nwords; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Collects transferred bytes and done pulses; also checks holding behaviour under back-pressure.
    task automatic drain(input int stall, input int budget);
        logic       prev_stalled;
        logic [7:0] prev_byte;
        int         after_done;
        byte_q.delete();
        done_cnt     = 0;
        after_done   = 0;
        prev_stalled = 1'b0;
        prev_byte    = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tx_ready = (stall == 0) || ((cyc % 3) == 2);
            if (prev_stalled) begin
                checkOutput("stall_valid", 64'(m_valid), 64'd1);
                checkOutput("stall_byte", 64'(m_byte), 64'(prev_byte));
            end
            if (m_valid && tx_ready) begin
                byte_q.push_back(m_byte);
            end
            prev_stalled = m_valid && !tx_ready;
            prev_byte    = m_byte;
            if (m_done) begin
                done_cnt++;
            end
            if (done_cnt > 0) begin
                after_done++;
            end
            if (after_done > 3) begin
                break;
            end
            step();
        end
        tx_ready = 1'b1;
    endtask

    task automatic compareBytes(input string name, input int nbytes, input logic [0:23][7:0] exp);
        logic [7:0] actual;
        checkOutput($sformatf("%s_nbytes", name), 64'(byte_q.size()), 64'(nbytes));
        for (int b = 0; b < nbytes; b++) begin
            actual = 8'hxx;
            if (b < byte_q.size()) begin
                actual = byte_q[b];
            end
            checkOutput($sformatf("%s_byte%0d", name, b), 64'(actual), 64'(exp[b]));
        end
    endtask

    task automatic runVector(input int i);
        string name;
        name = $sformatf("v%0d", i);
        sel  = vecs[i].dut;
        applyStimulus(vecs[i].dut, vecs[i].nwords, vecs[i].words, 1'b1);
        drain(vecs[i].stall, 400);
        compareBytes(name, vecs[i].nbytes, vecs[i].exp);
        checkOutput({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({name, "_count"}, 64'(m_count), 64'(vecs[i].exp_count));
        checkOutput({name, "_overflow"}, 64'(m_ovf), 64'(vecs[i].exp_ovf));
        checkOutput({name, "_busy_after"}, 64'(m_busy), 64'(vecs[i].exp_busy));
        checkOutput({name, "_valid_after"}, 64'(m_valid), 64'd0);
    endtask

    task automatic burstCheck(input string name, input logic [63:0] w0, input logic [63:0] w1,
                              input logic [0:23][7:0] exp);
        logic [0:5][63:0] words;
        sel   = 2;
        words = {w0, w1, 256'h0};
        for (int i = 0; i < 50; i++) begin
            step();
        end
        checkOutput({name, "_armed_busy"}, 64'(m_busy), 64'd1);
        checkOutput({name, "_armed_valid"}, 64'(m_valid), 64'd0);
        applyStimulus(2, 2, words, 1'b0);
        drain(0, 400);
        compareBytes(name, 4, exp);
        checkOutput({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({name, "_count"}, 64'(m_count), 64'd2);
        checkOutput({name, "_busy_after"}, 64'(m_busy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        bit hit;

        for (int i = 0; i < 5; i++) begin
            vecs[i] = '0;
        end

        vecs[0].dut = 0; vecs[0].nwords = 3; vecs[0].stall = 0; vecs[0].nbytes = 15;
        vecs[0].exp_count = 3; vecs[0].exp_ovf = 1'b0; vecs[0].exp_busy = 1'b0;
        vecs[0].words = {64'h0102030405, 64'h0A0B0C0D0E, 64'hFFFFFFFFFF, 192'h0};
        vecs[0].exp = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A,
                       8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 72'h0};

        vecs[1].dut = 1; vecs[1].nwords = 6; vecs[1].stall = 0; vecs[1].nbytes = 20;
        vecs[1].exp_count = 4; vecs[1].exp_ovf = 1'b1; vecs[1].exp_busy = 1'b0;
        vecs[1].words = {64'hA1000000B1, 64'hA2000000B2, 64'hA3000000B3,
                         64'hA4000000B4, 64'hA5000000B5, 64'hA6000000B6};
        vecs[1].exp = {8'hA1, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'hB2,
                       8'hA3, 8'h00, 8'h00, 8'h00, 8'hB3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'hB4, 32'h0};

        vecs[2].dut = 1; vecs[2].nwords = 3; vecs[2].stall = 0; vecs[2].nbytes = 15;
        vecs[2].exp_count = 3; vecs[2].exp_ovf = 1'b0; vecs[2].exp_busy = 1'b0;
        vecs[2].words = {64'h0102030405, 64'h0A0B0C0D0E, 64'hFFFFFFFFFF, 192'h0};
        vecs[2].exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                       8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 72'h0};

        vecs[3] = vecs[0];
        vecs[3].stall = 1;

        vecs[4].dut = 2; vecs[4].nwords = 1; vecs[4].stall = 0; vecs[4].nbytes = 2;
        vecs[4].exp_count = 1; vecs[4].exp_ovf = 1'b0; vecs[4].exp_busy = 1'b1;
        vecs[4].words = {64'hABC, 320'h0};
        vecs[4].exp = {8'hBC, 8'h0A, 176'h0};

        sel = 0;
        repeat (3) step();
        checkOutput("reset_tx_valid", 64'(m_valid), 64'd0);
        checkOutput("reset_tx_byte", 64'(m_byte), 64'd0);
        checkOutput("reset_busy", 64'(m_busy), 64'd0);
        checkOutput("reset_done", 64'(m_done), 64'd0);
        checkOutput("reset_overflow", 64'(m_ovf), 64'd0);
        checkOutput("reset_count", 64'(m_count), 64'd0);
        rst = 1'b0;
        step();

        runVector(0);

        // Strobes while idle must neither count nor flag overflow.
        in_valid = 1'b1;
        in_data  = 64'h1122334455;
        repeat (3) step();
        in_valid = 1'b0;
        step();
        checkOutput("idle_ignore_count", 64'(m_count), 64'd3);
        checkOutput("idle_ignore_busy", 64'(m_busy), 64'd0);
        checkOutput("idle_ignore_overflow", 64'(m_ovf), 64'd0);

        for (int i = 1; i < 4; i++) begin
            runVector(i);
        end

        // Reset arriving while the 7th byte is on the wire.
        sel = 0;
        applyStimulus(0, 3, vecs[0].words, 1'b1);
        sent = 0;
        hit  = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (m_valid && sent == 6) begin
                rst = 1'b1;
                #1;
                checkOutput("midsend_reset_valid", 64'(m_valid), 64'd0);
                checkOutput("midsend_reset_busy", 64'(m_busy), 64'd0);
                checkOutput("midsend_reset_count", 64'(m_count), 64'd0);
                checkOutput("midsend_reset_byte", 64'(m_byte), 64'd0);
                hit = 1'b1;
                break;
            end
            if (m_valid && tx_ready) begin
                sent++;
            end
            step();
        end
        checkOutput("midsend_reset_reached", 64'(hit), 64'd1);
        #1;
        rst = 1'b0;
        repeat (3) step();
        checkOutput("post_reset_idle_valid", 64'(m_valid), 64'd0);
        checkOutput("post_reset_idle_busy", 64'(m_busy), 64'd0);
        runVector(0);

        runVector(4);
        burstCheck("cont_burst1", 64'h123, 64'h456, {8'h23, 8'h01, 8'h56, 8'h04, 160'h0});
        burstCheck("cont_burst2", 64'h789, 64'hFED, {8'h89, 8'h07, 8'hED, 8'h0F, 160'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_uart_streamer.md
CAPTURE_UART_STREAMER -- requirements
Module: capture_uart_streamer

Interface
REQ-001 Parameter DATA_W, default 40: captured word width in bits; legal range 8..64.
REQ-002 Parameter DEPTH, default 1024: capture buffer depth in words; power of two, 2..4096.
REQ-003 Parameter MSB_FIRST, default 0: 0 = least significant byte sent first; 1 = most significant byte sent first.
REQ-004 Parameter CONTINUOUS, default 0: 0 = one-shot; 1 = re-arm automatically after each readout.
REQ-005 Derived constant NBYTES = ceil(DATA_W/8); derived constant CW = clog2(DEPTH+1).
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 arm  in  1  request a new capture; sampled only in IDLE.
REQ-009 in_valid  in  1  capture strobe (beamformer sum flag); high = in_data valid this cycle.
REQ-010 in_data  in  DATA_W  word to capture.
REQ-011 tx_ready  in  1  UART transmitter can accept a byte.
REQ-012 tx_valid  out  1  tx_byte holds a byte to send.
REQ-013 tx_byte  out  8  byte to the UART.
REQ-014 busy  out  1  high in ARMED, CAPTURE, FETCH and SEND.
REQ-015 done  out  1  one-cycle pulse when the last byte is accepted.
REQ-016 overflow  out  1  sticky; set when a word is dropped because the buffer is full.
REQ-017 count  out  CW  number of words stored in the current or last capture.

Function
REQ-018 The state machine SHALL have the states IDLE, ARMED, CAPTURE, FETCH, SEND and DONE.
REQ-019 IDLE SHALL move to ARMED when arm=1; arm SHALL be ignored in every other state.
REQ-020 ARMED with in_valid=1 SHALL write in_data to address 0 in the same cycle, set count=1, clear overflow and enter CAPTURE.
REQ-021 CAPTURE SHALL write in_data at address count and increment count on every in_valid=1 cycle while count<DEPTH.
REQ-022 In CAPTURE with in_valid=1 and count=DEPTH, the word SHALL be dropped and overflow set; count SHALL NOT wrap.
REQ-023 The first in_valid=0 cycle in CAPTURE SHALL end the capture: the read pointer is cleared and the state moves to FETCH; gaps are not bridged.
REQ-024 The RAM read latency SHALL be 1 cycle; FETCH SHALL issue the read address and load the word into the byte shifter one cycle later, then enter SEND.
REQ-025 SEND SHALL present the NBYTES bytes in the order set by MSB_FIRST; when DATA_W is not a multiple of 8, the top byte SHALL be zero-padded.
REQ-026 Handshake: a byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1.
REQ-027 While tx_valid=1 and tx_ready=0, tx_byte SHALL hold stable; tx_valid SHALL NOT drop before the transfer.
REQ-028 After the last byte of a word transfers, the next word SHALL be fetched (FETCH); after the last byte of word count-1 transfers, the state SHALL move to DONE.
REQ-029 tx_valid SHALL be low in FETCH, so there is a 2-cycle bubble between words; within a word, back-to-back bytes SHALL send with no gap.
REQ-030 DONE SHALL pulse done for 1 cycle, then enter IDLE (CONTINUOUS=0) or ARMED (CONTINUOUS=1).
REQ-031 in_valid SHALL be ignored in FETCH, SEND, DONE and IDLE; these words are not counted and do not set overflow.
REQ-032 count and overflow SHALL hold their values from the end of a capture until the next ARMED to CAPTURE transition.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, tx_valid=0, tx_byte=0, busy=0, done=0, overflow=0, count=0 and clear both pointers.
REQ-034 Reset asserted in the middle of a capture or a send SHALL abort it with no further tx_valid; RAM contents are not reset and are don't-care.

Structure
REQ-035 Package capture_uart_pkg SHALL hold the state enum and the NBYTES/CW helper functions.
REQ-036 Storage SHALL be a single sub-module, capture_ram: single-port synchronous RAM, DATA_W x DEPTH, 1-cycle registered read, inferable to block RAM.

Verification
REQ-037 DATA_W=40, arm, then in_valid high for 3 cycles with 0x0102030405, 0x0A0B0C0D0E, 0xFFFFFFFFFF, tx_ready=1 -> 15 bytes 05 04 03 02 01 0E 0D 0C 0B 0A FF x5; done once; count=3.
REQ-038 Same stimulus with MSB_FIRST=1 -> 01 02 03 04 05 0A ... ; DATA_W=12 with word 0xABC -> BC 0A.
REQ-039 DEPTH=4, in_valid high for 6 cycles -> count=4, overflow=1, 4 words (20 bytes) sent.
REQ-040 tx_ready toggled 1-of-3 cycles -> tx_byte stable while stalled; byte sequence unchanged; no byte lost or duplicated.
REQ-041 rst pulsed during the 7th byte of SEND -> tx_valid=0 in the same cycle, state IDLE; a new arm then capture works normally.
REQ-042 CONTINUOUS=1, two bursts of 2 words separated by 50 idle cycles after done -> two full readouts, no arm after the first.
